blk_timing: RTL and testbench
=============================

# blk_timing

Front-end timing stage of the block-luminance path. It watches the incoming video stream (`de_i`, `vs_i`, 24-bit pixel) and tiles the active frame into HBLKS×VBLKS blocks of HPX×VPX pixels. It emits one-cycle `h_save_o` and `v_save_o` strobes, together with a one-cycle-delayed copy of the pixel stream, directly into `blk_buffer`'s `h_save_i`, `v_save_i`, `de_i` and `wd_i`. It also flags frames whose line length or line count does not match the configured geometry.

## Interface
- HBLKS, 10, block columns per frame
- VBLKS, 10, block rows per frame
- HPX, 30, pixels per block horizontally
- VPX, 30, lines per block vertically
- clk_i  in  1  pixel clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- de_i  in  1  data enable, high during active pixels
- vs_i  in  1  vertical sync, active high; rising edge starts a frame
- wd_i  in  24  pixel {R,G,B}
- de_o  out  1  `de_i` delayed 1 cycle
- wd_o  out  24  `wd_i` delayed 1 cycle
- h_save_o  out  1  strobe on last pixel of each horizontal block, aligned with `wd_o`
- v_save_o  out  1  strobe after the last line of each block row
- geom_err_o  out  1  sticky geometry error, cleared at next frame start

## Operation
- Reset: all outputs 0, all counters 0, FSM in UNSYNC.
- FSM states:
  - UNSYNC: no strobes are emitted. `de_o`/`wd_o` still pass through.
  - RUN: counting.
  - DONE: all VBLKS rows complete. Lines are ignored until the next frame start.
- Transitions:
  - Any state → RUN on a `vs_i` rising edge. This clears the pixel, block-column, line and block-row counters and clears `geom_err_o`.
  - RUN → DONE on issuing the v_save of block row VBLKS-1.
- Counters:
  - `px_cnt` runs 0..HPX-1; `bc_cnt` runs 0..HBLKS-1; `ln_cnt` runs 0..VPX-1; `br_cnt` runs 0..VBLKS-1.
  - Each counter wraps to 0. Each carry advances the next counter.
- Horizontal (RUN, `de_i`=1):
  - `px_cnt` increments each pixel.
  - When `px_cnt`=HPX-1 and `bc_cnt`<HBLKS, `h_save_o` is asserted on the matching output cycle and `bc_cnt` increments.
  - Pixels after the HBLKS-th block saturate: no further h_save for that line, and `geom_err_o` is set.
- End of line (RUN, `de_i` 1→0):
  - If the line delivered fewer than HBLKS·HPX pixels, `geom_err_o` is set.
  - `px_cnt` and `bc_cnt` are cleared and `ln_cnt` increments.
  - If `ln_cnt` was VPX-1, `v_save_o` is asserted one cycle later, `ln_cnt` wraps and `br_cnt` increments.
- A `vs_i` rising edge while in RUN with `br_cnt`≠0 or `ln_cnt`≠0 (a short frame) sets `geom_err_o`, then the frame restarts. The error set by this edge persists into the new frame. It takes precedence over the clear.
- Lines arriving in DONE set `geom_err_o`.
- `de_i` high in the same cycle as a `vs_i` rising edge: the edge wins, and the pixel counts as pixel 0 of the new frame.

## Timing
- Latency: `de_o`, `wd_o` and `h_save_o` are all registered and arrive exactly 1 cycle after the input pixel. `h_save_o`=1 coincides with the block's last pixel on `wd_o`.
- `v_save_o` is 1 cycle wide. It occurs 2 cycles after the last active pixel, with `de_o`=0, and never coincides with `h_save_o`.
- Minimum horizontal blanking is 2 cycles. Blanking of 1 cycle is unsupported, and `geom_err_o` behaviour is then undefined.
- Reset asserted mid-frame: the block returns to UNSYNC immediately. No strobes are issued until a fresh `vs_i` rising edge.

## Structure
- The shared header holds the geometry defaults (HBLKS, VBLKS, HPX, VPX) and the derived `ACT_W`=HBLKS·HPX and `ACT_H`=VBLKS·VPX. `blk_buffer` uses the same values, so PXS=HPX·VPX.
- One sub-module, `wrap_cnt` (parameter MAX; ports: clear, enable, value, last), is instantiated four times.
- Edge detection and the FSM are local to `blk_timing`.

## Test plan
- HBLKS=2, VBLKS=2, HPX=3, VPX=2, blanking 4. Apply `vs_i` pulse, then 4 lines of 6 pixels:
  - `h_save_o` on output pixels 2 and 5 of every line.
  - `v_save_o` after lines 1 and 3.
  - `geom_err_o`=0.
- Same geometry, line 2 has 5 pixels → `geom_err_o` rises at that line's end. It is held until the next `vs_i` edge, then reads 0.
- A 7-pixel line → only 2 h_save strobes on that line; `geom_err_o`=1.
- Reset released mid-line with no `vs_i` → no h_save or v_save. After `vs_i`, normal strobes resume.
- `vs_i` edge after 3 lines → `geom_err_o`=1. The new frame counts from block 0 and its first `h_save_o` falls on pixel 2.
- A random pixel stream yields `wd_o`/`de_o` equal to the inputs delayed by exactly 1 cycle.

Source files
------------

// File: rtl/blk_timing_pkg.sv
// blk_timing_pkg: shared block geometry, derived frame sizes and FSM state type
package blk_timing_pkg;
  localparam int HBLKS = 10;
  localparam int VBLKS = 10;
  localparam int HPX = 30;
  localparam int VPX = 30;
  localparam int ACT_W = HBLKS * HPX;
  localparam int ACT_H = VBLKS * VPX;
  localparam int PXS = HPX * VPX;
  localparam int WD_W = 24;
  typedef enum logic [1:0] {UNSYNC, RUN, DONE} state_e;
  function automatic int cnt_w(input int max);
    return max < 1 ? 1 : $clog2(max + 1);
  endfunction
endpackage

// File: rtl/blk_timing_if.sv
// blk_timing_if: incoming video stream plus the delayed stream and save strobes
interface blk_timing_if;
  import blk_timing_pkg::*;
  logic de_i;
  logic vs_i;
  logic [WD_W-1:0] wd_i;
  logic de_o;
  logic [WD_W-1:0] wd_o;
  logic h_save_o;
  logic v_save_o;
  logic geom_err_o;
  modport master (output de_i, vs_i, wd_i, input de_o, wd_o, h_save_o, v_save_o, geom_err_o);
  modport slave (input de_i, vs_i, wd_i, output de_o, wd_o, h_save_o, v_save_o, geom_err_o);
endinterface

// File: rtl/blk_timing_wrap_cnt.sv
// wrap_cnt: 0..MAX counter; clear and enable together restart the count from the new pixel
module wrap_cnt
  import blk_timing_pkg::*;
#(
  parameter int MAX = 1,
  localparam int W = cnt_w(MAX)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] value,
  output logic         last
);
  logic [W-1:0] base;
  assign base = clear ? '0 : value;
  assign last = value == W'(MAX);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) value <= '0;
    else value <= enable ? (base == W'(MAX) ? '0 : base + W'(1)) : base;
endmodule

// File: rtl/blk_timing.sv
// blk_timing: tiles the active frame into blocks, emits h/v save strobes and flags bad geometry
module blk_timing
  import blk_timing_pkg::*;
#(
  parameter int HBLKS = blk_timing_pkg::HBLKS,
  parameter int VBLKS = blk_timing_pkg::VBLKS,
  parameter int HPX = blk_timing_pkg::HPX,
  parameter int VPX = blk_timing_pkg::VPX
) (
  input logic clk_i,
  input logic rst_ni,
  blk_timing_if.slave bus
);
  state_e state, state_d;
  logic vs_q, de_q, sat, h_q, v_q, err;
  logic [WD_W-1:0] wd_q;
  logic [cnt_w(HPX-1)-1:0] px_cnt;
  logic [cnt_w(HBLKS-1)-1:0] bc_cnt;
  logic [cnt_w(VPX-1)-1:0] ln_cnt;
  logic [cnt_w(VBLKS-1)-1:0] br_cnt;
  logic px_last, bc_last, ln_last, br_last;
  logic vs_rise, run, pix, line_end, restart, px_at_last, bc_at_last, sat_eff, hit, row_end, sat_d, err_d;
  // a pixel coinciding with the vs edge is pixel 0 of the new frame, so stale counter state is masked
  always_comb begin
    vs_rise = bus.vs_i & ~vs_q;
    run = state == RUN;
    pix = bus.de_i & (run | vs_rise);
    line_end = run & ~vs_rise & de_q & ~bus.de_i;
    restart = vs_rise | line_end;
    px_at_last = vs_rise ? (HPX == 1) : px_last;
    bc_at_last = vs_rise ? (HBLKS == 1) : bc_last;
    sat_eff = sat & ~vs_rise;
    hit = pix & px_at_last & ~sat_eff;
    row_end = line_end & ln_last;
    sat_d = (sat & ~restart) | (hit & bc_at_last);
    err_d = vs_rise ? run & ((ln_cnt != '0) | (br_cnt != '0))
          : err | (pix & sat_eff) | (line_end & ~sat) | (bus.de_i & (state == DONE));
    state_d = vs_rise ? RUN : (row_end & br_last) ? DONE : state;
  end
  wrap_cnt #(.MAX(HPX-1)) u_px (
    .clk_i, .rst_ni, .clear(restart), .enable(pix), .value(px_cnt), .last(px_last)
  );
  wrap_cnt #(.MAX(HBLKS-1)) u_bc (
    .clk_i, .rst_ni, .clear(restart), .enable(hit), .value(bc_cnt), .last(bc_last)
  );
  wrap_cnt #(.MAX(VPX-1)) u_ln (
    .clk_i, .rst_ni, .clear(vs_rise), .enable(line_end), .value(ln_cnt), .last(ln_last)
  );
  wrap_cnt #(.MAX(VBLKS-1)) u_br (
    .clk_i, .rst_ni, .clear(vs_rise), .enable(row_end), .value(br_cnt), .last(br_last)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= UNSYNC;
      vs_q <= 1'b0;
      de_q <= 1'b0;
      wd_q <= '0;
      sat <= 1'b0;
      h_q <= 1'b0;
      v_q <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      vs_q <= bus.vs_i;
      de_q <= bus.de_i;
      wd_q <= bus.wd_i;
      sat <= sat_d;
      h_q <= hit;
      v_q <= row_end;
      err <= err_d;
    end
  assign bus.de_o = de_q;
  assign bus.wd_o = wd_q;
  assign bus.h_save_o = h_q;
  assign bus.v_save_o = v_q;
  assign bus.geom_err_o = err;
endmodule

// File: tb/tb_blk_timing.sv
// tb_blk_timing: directed and random video frames checked against a pixel-position reference model
module tb_blk_timing;
  localparam int HBLKS = 2;
  localparam int VBLKS = 2;
  localparam int HPX = 3;
  localparam int VPX = 2;
  localparam int ACT_W = HBLKS * HPX;
  localparam int ACT_H = VBLKS * VPX;
  logic clk = 1'b0;
  logic rst_n;
  int n_vec = 0;
  int n_err = 0;
  int h_obs = 0;
  int v_obs = 0;
  int mode, pix, lines;
  bit err, pde, pvs;
  bit e_de, e_h, e_v, e_err;
  logic [23:0] e_wd;
  blk_timing_if bus ();
  blk_timing #(.HBLKS(HBLKS), .VBLKS(VBLKS), .HPX(HPX), .VPX(VPX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  // mode: 0 = not synced, 1 = counting a frame, 2 = frame complete
  task automatic model(input bit r, input bit de, input bit vs, input logic [23:0] wd);
    bit rise;
    e_h = 0;
    e_v = 0;
    if (!r) begin
      mode = 0; pix = 0; lines = 0; err = 0; pde = 0; pvs = 0;
      e_de = 0; e_wd = '0; e_err = 0;
      return;
    end
    rise = vs && !pvs;
    if (rise) begin
      err = (mode == 1) && (lines > 0);
      mode = 1; lines = 0; pix = 0;
    end else if (mode == 1 && pde && !de) begin
      if (pix < ACT_W) err = 1;
      lines++;
      pix = 0;
      e_v = (lines % VPX) == 0;
      if (lines == ACT_H) mode = 2;
    end
    if (de && mode == 1) begin
      e_h = (pix < ACT_W) && (pix % HPX == HPX - 1);
      if (pix >= ACT_W) err = 1;
      pix++;
    end else if (de && mode == 2) err = 1;
    e_de = de; e_wd = wd; e_err = err; pde = de; pvs = vs;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit r, input bit de, input bit vs);
    logic [23:0] wd;
    wd = 24'($urandom);
    rst_n = r; bus.de_i = de; bus.vs_i = vs; bus.wd_i = wd;
    model(r, de, vs, wd);
    @(negedge clk);
    chk("de_o", 32'(bus.de_o), 32'(e_de));
    chk("wd_o", 32'(bus.wd_o), 32'(e_wd));
    chk("h_save_o", 32'(bus.h_save_o), 32'(e_h));
    chk("v_save_o", 32'(bus.v_save_o), 32'(e_v));
    chk("geom_err_o", 32'(bus.geom_err_o), 32'(e_err));
    h_obs += int'(bus.h_save_o);
    v_obs += int'(bus.v_save_o);
  endtask
  task automatic line(input int n, input int blank);
    for (int i = 0; i < n; i++) cyc(1, 1, 0);
    for (int i = 0; i < blank; i++) cyc(1, 0, 0);
  endtask
  task automatic vs_pulse();
    cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 0); cyc(1, 0, 0);
  endtask
  initial begin
    bus.de_i = 0; bus.vs_i = 0; bus.wd_i = '0; rst_n = 0;
    repeat (3) cyc(0, 0, 0);
    repeat (3) cyc(1, 0, 0);
    h_obs = 0; v_obs = 0;
    vs_pulse();
    repeat (4) line(6, 4);
    chk("frame_h_count", h_obs, 8);
    chk("frame_v_count", v_obs, 2);
    chk("frame_err", 32'(bus.geom_err_o), 0);
    vs_pulse();
    line(6, 4); line(5, 4);
    chk("short_line_err", 32'(bus.geom_err_o), 1);
    line(6, 4); line(6, 4);
    chk("short_line_held", 32'(bus.geom_err_o), 1);
    vs_pulse();
    chk("err_cleared", 32'(bus.geom_err_o), 0);
    line(6, 4);
    h_obs = 0;
    line(7, 4);
    chk("long_line_h", h_obs, 2);
    chk("long_line_err", 32'(bus.geom_err_o), 1);
    line(6, 4); line(6, 4);
    vs_pulse();
    line(6, 4);
    cyc(1, 1, 0); cyc(1, 1, 0);
    cyc(0, 1, 0); cyc(0, 1, 0);
    h_obs = 0; v_obs = 0;
    cyc(1, 1, 0); cyc(1, 1, 0);
    repeat (4) cyc(1, 0, 0);
    repeat (4) line(6, 4);
    chk("unsync_h", h_obs, 0);
    chk("unsync_v", v_obs, 0);
    vs_pulse();
    h_obs = 0; v_obs = 0;
    repeat (4) line(6, 4);
    chk("resync_h", h_obs, 8);
    chk("resync_v", v_obs, 2);
    vs_pulse();
    repeat (3) line(6, 4);
    vs_pulse();
    chk("short_frame_err", 32'(bus.geom_err_o), 1);
    h_obs = 0;
    cyc(1, 1, 0); cyc(1, 1, 0);
    chk("new_frame_h0", h_obs, 0);
    cyc(1, 1, 0);
    chk("new_frame_h1", h_obs, 1);
    line(3, 4);
    h_obs = 0;
    cyc(1, 1, 1);
    line(5, 4);
    chk("vs_de_h", h_obs, 2);
    repeat (3) line(6, 4);
    repeat (8) begin
      vs_pulse();
      repeat ($urandom_range(3, 6)) line($urandom_range(4, 8), $urandom_range(2, 5));
    end
    repeat (200) cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
